i4003_driver: RTL and testbench

//  Shifts a parallel word into a chain of i4003 shift registers as their master.

---
 rtl/i4003_pkg.sv | 19 +
 rtl/i4003_phase_timer.sv | 28 ++
 rtl/i4003_driver.sv | 141 ++++++++++++++
 tb/tb_i4003_driver.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/i4003_pkg.sv
// Shared definitions for the i4003 shift-register chain driver and its bench model.
package i4003_pkg;

    // Time from a cp rising edge until the i4003 output latches settle.
    localparam int I4003_LATCH_NS = 250;

    typedef enum logic [1:0] {
        PH_IDLE = 2'd0,
        PH_LOW  = 2'd1,
        PH_HIGH = 2'd2,
        PH_TAIL = 2'd3
    } phase_e;

    // Converts a duration in ns to whole system-clock cycles, rounding up.
    function automatic int nstocy(input int ns, input int tcy);
        return (ns + tcy - 1) / tcy;
    endfunction

endpackage

// File: rtl/i4003_phase_timer.sv
// Phase timer: loadable down-counter, tc_o high while the count sits at zero.
// Latency: load takes effect on the next edge; a load of N gives N+1 cycles to tc.
// Backpressure: none, free-running once loaded.
module i4003_phase_timer #(
    parameter int CNT_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;

    assign tc_o = (cnt_q == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (!tc_o) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/i4003_driver.sv
// i4003 chain master: shifts a host word out on cp/serial_data and captures serial_return.
// Latency: accept to done pulse is (2*WIDTH+1)*HALF_CY cycles.
// Backpressure: load_ready low for the whole frame; load_valid while busy is dropped.
module i4003_driver
    import i4003_pkg::*;
#(
    parameter int SYSCLK_TCY  = 20,
    parameter int WIDTH       = 10,
    parameter int CP_HALF_NS  = 500,
    parameter int BLANK_SHIFT = 1
) (
    input  logic             sysclk_i,
    input  logic             rst_ni,
    input  logic             load_valid_i,
    output logic             load_ready_o,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             serial_return_i,
    output logic             cp_o,
    output logic             serial_data_o,
    output logic             enable_o,
    output logic [WIDTH-1:0] rx_data_o,
    output logic             done_o
);

    localparam int HALF_CY = nstocy(CP_HALF_NS, SYSCLK_TCY);
    localparam int CNT_W   = (HALF_CY > 1) ? $clog2(HALF_CY) : 1;
    localparam int BC_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CNT_W-1:0] HALF_LD  = CNT_W'(HALF_CY - 1);
    localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(WIDTH - 1);

    phase_e           state_q;
    logic             ready_q;
    logic             cp_q;
    logic             sd_q;
    logic             en_q;
    logic             done_q;
    logic [BC_W-1:0]  bit_cnt_q;
    logic [WIDTH-1:0] tx_shift_q;
    logic [WIDTH-1:0] rx_shift_q;
    logic [WIDTH-1:0] rx_shift_d;
    logic [WIDTH-1:0] rx_data_q;

    logic accept;
    logic tmr_load;
    logic tmr_tc;

    assign accept     = load_valid_i & ready_q;
    assign rx_shift_d = {rx_shift_q[WIDTH-2:0], serial_return_i};

    // The timer is rearmed on every phase change except the end of TAIL.
    assign tmr_load = accept | (tmr_tc & ((state_q == PH_LOW) | (state_q == PH_HIGH)));

    i4003_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk_i      (sysclk_i),
        .rst_ni     (rst_ni),
        .load_i     (tmr_load),
        .load_val_i (HALF_LD),
        .tc_o       (tmr_tc)
    );

    always_ff @(posedge sysclk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= PH_IDLE;
            ready_q    <= 1'b1;
            cp_q       <= 1'b0;
            sd_q       <= 1'b0;
            en_q       <= 1'b0;
            done_q     <= 1'b0;
            bit_cnt_q  <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                PH_IDLE: begin
                    cp_q <= 1'b0;
                    if (accept) begin
                        state_q    <= PH_LOW;
                        ready_q    <= 1'b0;
                        bit_cnt_q  <= '0;
                        tx_shift_q <= load_data_i;
                        sd_q       <= load_data_i[WIDTH-1];
                        if (BLANK_SHIFT != 0) begin
                            en_q <= 1'b0;
                        end
                    end
                end
                PH_LOW: begin
                    // Sample late in LOW so the chain output has long since settled.
                    if (tmr_tc) begin
                        rx_shift_q <= rx_shift_d;
                        cp_q       <= 1'b1;
                        state_q    <= PH_HIGH;
                    end
                end
                PH_HIGH: begin
                    if (tmr_tc) begin
                        cp_q <= 1'b0;
                        if (bit_cnt_q < LAST_BIT) begin
                            bit_cnt_q  <= bit_cnt_q + BC_W'(1);
                            tx_shift_q <= tx_shift_q << 1;
                            sd_q       <= tx_shift_q[WIDTH-2];
                            state_q    <= PH_LOW;
                        end else begin
                            state_q <= PH_TAIL;
                        end
                    end
                end
                PH_TAIL: begin
                    if (tmr_tc) begin
                        rx_data_q <= rx_shift_q;
                        done_q    <= 1'b1;
                        en_q      <= 1'b1;
                        ready_q   <= 1'b1;
                        state_q   <= PH_IDLE;
                    end
                end
                default: state_q <= PH_IDLE;
            endcase
        end
    end

    assign load_ready_o  = ready_q;
    assign cp_o          = cp_q;
    assign serial_data_o = sd_q;
    assign enable_o      = en_q;
    assign rx_data_o     = rx_data_q;
    assign done_o        = done_q;

    // A cp phase this short lets serial_data move before the i4003 latch point.
    if (HALF_CY < nstocy(I4003_LATCH_NS, SYSCLK_TCY) + 2) begin : g_half_cy_illegal
        always @(posedge sysclk_i) begin
            $error("i4003_driver: HALF_CY=%0d is below the i4003 latch minimum", HALF_CY);
        end
    end

endmodule

// File: tb/tb_i4003_driver.sv
// Directed bench: two drivers (BLANK_SHIFT=1 and 0) each looped through an i4003 chain model.
`timescale 1ns/1ps
module tb_i4003_driver;
    import i4003_pkg::*;

    logic       sysclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_valid = 1'b0;
    logic [9:0] load_data = '0;

    logic       ready1, cp1, sd1, en1, done1, sret1;
    logic [9:0] rx1;
    logic       ready0, cp0, sd0, en0, done0, sret0;
    logic [9:0] rx0;

    logic [9:0] chain1 = '0;
    logic [9:0] chain0 = '0;
    logic       lat1, lat0;
    logic [9:0] par1;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int t_acc = 0;
    int t_done = 0;

    int pulses1 = 0, wbad1 = 0, hi_len1 = 0, sdviol = 0, done_cnt1 = 0;
    int en_busy1 = 0, enlow_busy0 = 0, dmis = 0;
    logic prev_cp1 = 1'b0, prev_sd1 = 1'b0, prev_sd0 = 1'b0;

    always #10 sysclk = ~sysclk;
    always @(posedge sysclk) cyc++;

    i4003_driver dut1 (
        .sysclk_i(sysclk), .rst_ni(rst_n), .load_valid_i(load_valid), .load_ready_o(ready1),
        .load_data_i(load_data), .serial_return_i(sret1), .cp_o(cp1), .serial_data_o(sd1),
        .enable_o(en1), .rx_data_o(rx1), .done_o(done1)
    );

    i4003_driver #(.BLANK_SHIFT(0)) dut0 (
        .sysclk_i(sysclk), .rst_ni(rst_n), .load_valid_i(load_valid), .load_ready_o(ready0),
        .load_data_i(load_data), .serial_return_i(sret0), .cp_o(cp0), .serial_data_o(sd0),
        .enable_o(en0), .rx_data_o(rx0), .done_o(done0)
    );

    // i4003 chain models: shift on cp rise, outputs settle after the latch delay.
    assign sret1 = chain1[9];
    assign sret0 = chain0[9];
    assign par1  = en1 ? chain1 : 10'h000;

    always @(posedge cp1) begin
        lat1 = sd1;
        #(I4003_LATCH_NS);
        chain1 = {chain1[8:0], lat1};
    end

    always @(posedge cp0) begin
        lat0 = sd0;
        #(I4003_LATCH_NS);
        chain0 = {chain0[8:0], lat0};
    end

    always @(negedge sysclk) begin
        if (cp1 && !prev_cp1) begin
            pulses1++;
            hi_len1 = 1;
        end else if (cp1) begin
            hi_len1++;
        end else if (prev_cp1 && hi_len1 != 25) begin
            wbad1++;
        end
        if (cp1 && sd1 != prev_sd1) sdviol++;
        if (cp0 && sd0 != prev_sd0) sdviol++;
        if (done1) done_cnt1++;
        if (done1 != done0) dmis++;
        if (!ready1 && en1) en_busy1++;
        if (!ready0 && !en0) enlow_busy0++;
        prev_cp1 = cp1;
        prev_sd1 = sd1;
        prev_sd0 = sd0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input logic [9:0] w);
        load_data  = w;
        load_valid = 1'b1;
        @(posedge sysclk);
        #1;
        t_acc      = cyc;
        load_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        int k;
        k = 0;
        while (!done1 && k < 2000) begin
            @(negedge sysclk);
            k++;
        end
        t_done = cyc;
        lat    = cyc - t_acc;
    endtask

    initial begin
        int lat, s_p, s_w, s_d, s_e, s_e0, rdy_seen;
        logic [9:0] w, prev_w, exp_rx0;

        rst_n = 1'b0;
        repeat (3) @(negedge sysclk);
        chk("rst_cp", 32'(cp1), 32'd0);
        chk("rst_sd", 32'(sd1), 32'd0);
        chk("rst_en", 32'(en1), 32'd0);
        chk("rst_rx", 32'(rx1), 32'd0);
        chk("rst_done", 32'(done1), 32'd0);
        chk("rst_ready", 32'(ready1), 32'd1);
        @(negedge sysclk) rst_n = 1'b1;
        @(negedge sysclk);

        // Reset in the middle of a cp high phase.
        start_frame(10'h155);
        lat = 0;
        while (!cp1 && lat < 200) begin
            @(negedge sysclk);
            lat++;
        end
        chk("t1_cp_rose", 32'(cp1), 32'd1);
        repeat (10) @(negedge sysclk);
        s_d = done_cnt1;
        #3 rst_n = 1'b0;
        #1;
        chk("t1_cp_async", 32'(cp1), 32'd0);
        chk("t1_en", 32'(en1), 32'd0);
        @(negedge sysclk) rst_n = 1'b1;
        repeat (3) @(negedge sysclk);
        chk("t1_ready", 32'(ready1), 32'd1);
        chk("t1_no_done", 32'(done_cnt1 - s_d), 32'd0);

        // First full frame.
        s_p = pulses1;
        s_w = wbad1;
        s_e = en_busy1;
        s_d = done_cnt1;
        start_frame(10'h2A5);
        wait_done(lat);
        chk("t2_latency", 32'(lat), 32'd525);
        chk("t2_pulses", 32'(pulses1 - s_p), 32'd10);
        chk("t2_width", 32'(wbad1 - s_w), 32'd0);
        chk("t2_en", 32'(en1), 32'd1);
        chk("t2_chain", 32'(chain1), 32'h2A5);
        chk("t2_parallel", 32'(par1), 32'h2A5);
        chk("t2_ready_at_done", 32'(ready1), 32'd1);

        // Back-to-back frame, accepted in the done cycle.
        s_e0 = enlow_busy0;
        start_frame(10'h15A);
        chk("t3_gap", 32'(t_acc - t_done), 32'd1);
        repeat (100) @(negedge sysclk);
        chk("t3_en_blank", 32'(en1), 32'd0);
        chk("t3_en_hold", 32'(en0), 32'd1);
        chk("t3_ready", 32'(ready1), 32'd0);
        wait_done(lat);
        chk("t3_latency", 32'(lat), 32'd525);
        chk("t3_rx", 32'(rx1), 32'h2A5);
        chk("t3_chain", 32'(chain1), 32'h15A);

        // Host keeps offering a word during a frame; it must be dropped.
        start_frame(10'h0C3);
        load_data  = 10'h3FF;
        load_valid = 1'b1;
        rdy_seen   = 0;
        repeat (400) begin
            @(negedge sysclk);
            if (ready1) rdy_seen++;
        end
        load_valid = 1'b0;
        chk("t4_ready_low", 32'(rdy_seen), 32'd0);
        wait_done(lat);
        chk("t4_latency", 32'(lat), 32'd525);
        chk("t4_chain", 32'(chain1), 32'h0C3);
        chk("t4_rx", 32'(rx1), 32'h15A);
        chk("t4_parallel", 32'(par1), 32'h0C3);
        @(negedge sysclk);
        chk("t4_done_1cyc", 32'(done1), 32'd0);
        chk("t4_done_count", 32'(done_cnt1 - s_d), 32'd3);

        chk("t5_blank_en", 32'(en_busy1 - s_e), 32'd0);
        chk("t5_hold_en", 32'(enlow_busy0 - s_e0), 32'd0);
        chk("t5_en0_final", 32'(en0), 32'd1);

        // Random words: chain contents and read-back of the previous word.
        s_w = wbad1;
        prev_w  = 10'h0C3;
        exp_rx0 = 10'h0C3;
        for (int i = 0; i < 40; i++) begin
            w = 10'($urandom);
            start_frame(w);
            wait_done(lat);
            chk("t6_chain", 32'(chain1), 32'(w));
            chk("t6_rx", 32'(rx1), 32'(prev_w));
            exp_rx0 = prev_w;
            prev_w  = w;
        end
        chk("t6_sd_stable", 32'(sdviol), 32'd0);
        chk("t6_width", 32'(wbad1 - s_w), 32'd0);
        chk("t6_chain0", 32'(chain0), 32'(prev_w));
        chk("t6_rx0", 32'(rx0), 32'(exp_rx0));
        chk("t6_done_align", 32'(dmis), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
